prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream feeder for the RAM/MAR stage. Receives a program image as a byte stream over a valid/ready handshake and writes it into RAM through the shared 8-bit bus.
- For each byte it sequences the MAR load, then the RAM write. While loading, it holds the CPU off the bus.
- Replaces manual dipswitch programming for simulation and board bring-up.
- Top level converts ram_we to the RAM's active-low write path and muxes bus_out onto the bus when bus_oe is high.

Parameters:
- ADDR_W, 4, MAR/RAM address width.
- DATA_W, 8, bus and RAM word width.
- DEPTH, 16, number of RAM words (2**ADDR_W).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clear_n  input  1  asynchronous active-low reset.
- start  input  1  begin a load session; sampled only in IDLE, DONE or ERROR.
- abort  input  1  synchronous abandon of the current session.
- rx_data  input  DATA_W  incoming stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- bus_out  output  DATA_W  value driven toward the bus (address or data).
- bus_oe  output  1  bus_out owns the bus.
- mar_load  output  1  one-cycle MAR load strobe; address is on bus_out[ADDR_W-1:0].
- ram_we  output  1  one-cycle RAM write strobe; data is on bus_out.
- cpu_hold  output  1  CPU clock/control gated off.
- busy  output  1  session in progress.
- done  output  1  last session completed with a good checksum.
- error  output  1  last session failed (checksum mismatch or abort).
- bytes_written  output  ADDR_W+1  count of RAM writes in the current or last session.

Behaviour:
- Reset (clear_n low, asynchronous):
  - state goes to IDLE.
  - All outputs are 0: bus_out=0, bus_oe=0, mar_load=0, ram_we=0, cpu_hold=0, rx_ready=0, busy=0, done=0, error=0, bytes_written=0.
  - Internal address, length and running sum are cleared.
  - Reset mid-session leaves RAM partially written; no cleanup is performed.
- Handshake:
  - A byte is accepted on a rising edge where rx_valid and rx_ready are both 1.
  - rx_ready is 1 only in GET_LEN, GET_BYTE and GET_SUM.
  - rx_data is ignored when no byte is accepted.
- Frame format:
  - First byte is LEN. LEN[ADDR_W:0] gives the number of data bytes. LEN=0 or LEN>DEPTH is treated as DEPTH.
  - Next come LEN data bytes, written to addresses 0,1,2,... in order.
  - Last byte is SUM, which must equal the 8-bit sum (mod 256) of the data bytes.
- States:
  - IDLE: outputs are idle. start → GET_LEN; on that transition busy=1, cpu_hold=1, done=0, error=0, bytes_written=0, addr=0, sum=0.
  - GET_LEN: on accept, latch the effective length → GET_BYTE.
  - GET_BYTE: on accept, latch the byte, sum += byte → SET_ADDR.
  - SET_ADDR (1 cycle): bus_oe=1, bus_out={0,addr}, mar_load=1 → WRITE.
  - WRITE (1 cycle): bus_oe=1, bus_out=latched byte, ram_we=1. bytes_written+1 and addr+1 at the end of this cycle. If bytes_written+1 equals length → GET_SUM, else → GET_BYTE.
  - GET_SUM: on accept, if byte == sum → DONE, else → ERROR.
  - DONE: busy=0, cpu_hold=0, done=1.
  - ERROR: busy=0, cpu_hold=0, error=1.
  - In DONE and ERROR, flags and bytes_written hold until the next start.
- Timing:
  - Minimum 3 cycles per data byte (accept, SET_ADDR, WRITE).
  - Minimum session time is 3*LEN+2 cycles plus stall cycles.
  - mar_load and ram_we are never high in the same cycle and never high outside SET_ADDR/WRITE.
  - bus_oe is high exactly in SET_ADDR and WRITE.
- Boundary conditions:
  - addr wraps from DEPTH-1 to 0, but is never reached beyond length.
  - bytes_written saturates at DEPTH.
  - start while busy is ignored.
  - start in DONE or ERROR begins a new session immediately (same transition as from IDLE).
  - abort in any busy state → ERROR next cycle. A strobe scheduled for that cycle is suppressed; a write that already happened is not undone.
  - abort and start together in IDLE: abort wins, stays in IDLE.
  - rx_valid held low leaves the FSM stalled indefinitely in a GET_* state with cpu_hold=1.

Test Plan:
- Reset: clear_n low mid-WRITE → all outputs 0 asynchronously (before the next clk edge); state IDLE after release.
- Nominal load: start, then LEN=3, bytes 0x1E,0x2F,0xE0, SUM=0x2D → mar_load pulses with bus_out=0,1,2; ram_we pulses with 0x1E,0x2F,0xE0; done=1, error=0, bytes_written=3, cpu_hold falls.
- Bad checksum: same frame with SUM=0x2C → three writes occur; error=1, done=0.
- Full/zero length: LEN=0x00 with 16 bytes 0x01..0x10, SUM=0x88 → 16 writes to addresses 0..15; bytes_written=16, done=1. Repeat with LEN=0x25 → identical result.
- Stalls: rx_valid toggling every other cycle → no extra strobes; rx_ready low in SET_ADDR/WRITE; sequence as in the nominal case.
- Abort: abort asserted during the second SET_ADDR → no mar_load that cycle; error=1, bytes_written=1. A subsequent start plus a valid frame gives done=1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed, checksummed program image into RAM
// through the shared bus. Each data byte produces a MAR load cycle followed by
// a RAM write cycle, and the CPU is held off the bus for the whole session.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_clear_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic [DATA_W-1:0] o_bus_out,
  output logic              o_bus_oe,
  output logic              o_mar_load,
  output logic              o_ram_we,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_bytes_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_LEN,
    S_GET_BYTE,
    S_SET_ADDR,
    S_WRITE,
    S_GET_SUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_bytes_written;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_sum;
  logic                w_accept;
  logic                w_start_ok;
  logic [ADDR_W:0]     w_len_eff;
  logic [ADDR_W:0]     w_count_inc;

  // A byte moves only when both sides agree; abort always beats start when idle.
  assign w_accept    = o_rx_ready & i_rx_valid;
  assign w_start_ok  = i_start & ~i_abort &
                       ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
  assign w_count_inc = r_bytes_written + (ADDR_W+1)'(1);
  // Zero or oversize lengths (judged on the whole LEN byte) load the full RAM.
  assign w_len_eff   = ((i_rx_data == '0) || (i_rx_data > DATA_W'(DEPTH))) ?
                       LP_DEPTH : i_rx_data[ADDR_W:0];

  // State register.
  always_ff @(posedge i_clk or negedge i_clear_n) begin
    if (!i_clear_n) r_state <= S_IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state logic; abort from any busy state goes straight to ERROR.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (w_start_ok) w_next_state = S_GET_LEN;
      S_GET_LEN: begin
        if (i_abort)       w_next_state = S_ERROR;
        else if (w_accept) w_next_state = S_GET_BYTE;
      end
      S_GET_BYTE: begin
        if (i_abort)       w_next_state = S_ERROR;
        else if (w_accept) w_next_state = S_SET_ADDR;
      end
      S_SET_ADDR: begin
        if (i_abort) w_next_state = S_ERROR;
        else         w_next_state = S_WRITE;
      end
      S_WRITE: begin
        if (i_abort)                  w_next_state = S_ERROR;
        else if (w_count_inc == r_len) w_next_state = S_GET_SUM;
        else                          w_next_state = S_GET_BYTE;
      end
      S_GET_SUM: begin
        if (i_abort)       w_next_state = S_ERROR;
        else if (w_accept) w_next_state = (i_rx_data == r_sum) ? S_DONE : S_ERROR;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Session datapath: length, address, running sum, held byte and write count.
  always_ff @(posedge i_clk or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_addr          <= '0;
      r_len           <= '0;
      r_bytes_written <= '0;
      r_data          <= '0;
      r_sum           <= '0;
    end else if (w_start_ok) begin
      r_addr          <= '0;
      r_bytes_written <= '0;
      r_sum           <= '0;
    end else if (!i_abort) begin
      case (r_state)
        S_GET_LEN: if (w_accept) r_len <= w_len_eff;
        S_GET_BYTE: begin
          if (w_accept) begin
            r_data <= i_rx_data;
            r_sum  <= r_sum + i_rx_data;
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + ADDR_W'(1);
          if (r_bytes_written != LP_DEPTH) r_bytes_written <= w_count_inc;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; an abort suppresses the strobe of its cycle.
  always_comb begin
    o_rx_ready      = 1'b0;
    o_bus_out       = '0;
    o_bus_oe        = 1'b0;
    o_mar_load      = 1'b0;
    o_ram_we        = 1'b0;
    o_cpu_hold      = 1'b0;
    o_busy          = 1'b0;
    o_done          = 1'b0;
    o_error         = 1'b0;
    o_bytes_written = r_bytes_written;
    case (r_state)
      S_GET_LEN, S_GET_BYTE, S_GET_SUM: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
        o_cpu_hold = 1'b1;
      end
      S_SET_ADDR: begin
        o_busy                 = 1'b1;
        o_cpu_hold             = 1'b1;
        o_bus_oe               = 1'b1;
        o_bus_out[ADDR_W-1:0]  = r_addr;
        o_mar_load             = ~i_abort;
      end
      S_WRITE: begin
        o_busy     = 1'b1;
        o_cpu_hold = 1'b1;
        o_bus_oe   = 1'b1;
        o_bus_out  = r_data;
        o_ram_we   = ~i_abort;
      end
      S_DONE:  o_done  = 1'b1;
      S_ERROR: o_error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames into prog_loader with a small bus/RAM model
// that records every MAR load and RAM write for comparison.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       clearN;
  logic       start;
  logic       abort;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic [7:0] busOut;
  logic       busOe;
  logic       marLoad;
  logic       ramWe;
  logic       cpuHold;
  logic       busy;
  logic       done;
  logic       error;
  logic [4:0] bytesWritten;

  int checks = 0;
  int fails = 0;
  int violations = 0;

  logic [7:0] frameData[$];
  logic [3:0] marQ[$];
  logic [7:0] weQ[$];
  logic [7:0] ramModel[16];
  logic [3:0] marModel;

  prog_loader dut (
    .i_clk(clk), .i_clear_n(clearN), .i_start(start), .i_abort(abort),
    .i_rx_data(rxData), .i_rx_valid(rxValid), .o_rx_ready(rxReady),
    .o_bus_out(busOut), .o_bus_oe(busOe), .o_mar_load(marLoad), .o_ram_we(ramWe),
    .o_cpu_hold(cpuHold), .o_busy(busy), .o_done(done), .o_error(error),
    .o_bytes_written(bytesWritten)
  );

  always #5 clk = ~clk;

  // Mid-cycle bus monitor: records strobes into a RAM model and counts rule breaks.
  always @(negedge clk) begin
    if (marLoad) begin
      marQ.push_back(busOut[3:0]);
      marModel = busOut[3:0];
    end
    if (ramWe) begin
      weQ.push_back(busOut);
      ramModel[marModel] = busOut;
    end
    if (marLoad && ramWe) violations++;
    if ((marLoad || ramWe) && !busOe) violations++;
    if (busOe && rxReady) violations++;
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one stream byte and waits (bounded) until it is accepted.
  task automatic applyStimulus(input logic [7:0] b, input bit stall);
    bit acc = 1'b0;
    int n = 0;
    if (stall) begin
      rxValid = 1'b0;
      rxData  = 8'hA5;
      @(posedge clk); #1;
    end
    rxData  = b;
    rxValid = 1'b1;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = rxReady;
      @(posedge clk); #1;
      n++;
    end
    rxValid = 1'b0;
    if (!acc) checkOutput("handshake timeout", 32'd0, 32'd1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("session open {busy,hold,ready}", {29'd0, busy, cpuHold, rxReady}, 32'd7);
    @(posedge clk); #1;
  endtask

  task automatic clearLogs();
    marQ.delete();
    weQ.delete();
    for (int i = 0; i < 16; i++) ramModel[i] = 8'h00;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("idle timeout", 32'd0, 32'd1);
  endtask

  task automatic runFrame(input logic [7:0] lenByte, input logic [7:0] sumByte, input bit stall);
    clearLogs();
    pulseStart();
    applyStimulus(lenByte, stall);
    foreach (frameData[i]) applyStimulus(frameData[i], stall);
    applyStimulus(sumByte, stall);
    waitIdle();
  endtask

  task automatic checkFrame(input string name, input bit expDone, input int expCount);
    checkOutput({name, " done"}, {31'd0, done}, {31'd0, expDone});
    checkOutput({name, " error"}, {31'd0, error}, {31'd0, !expDone});
    checkOutput({name, " bytes_written"}, {27'd0, bytesWritten}, expCount);
    checkOutput({name, " cpu_hold"}, {31'd0, cpuHold}, 32'd0);
    checkOutput({name, " mar_load count"}, marQ.size(), expCount);
    checkOutput({name, " ram_we count"}, weQ.size(), expCount);
    for (int i = 0; i < expCount && i < marQ.size(); i++)
      checkOutput($sformatf("%s mar addr %0d", name, i), {28'd0, marQ[i]}, i & 15);
    for (int i = 0; i < expCount && i < weQ.size(); i++)
      checkOutput($sformatf("%s write data %0d", name, i), {24'd0, weQ[i]}, {24'd0, frameData[i]});
    for (int i = 0; i < expCount; i++)
      checkOutput($sformatf("%s ram[%0d]", name, i), {24'd0, ramModel[i]}, {24'd0, frameData[i]});
  endtask

  function automatic logic [31:0] allOutputs();
    return {11'd0, rxReady, busOe, marLoad, ramWe, cpuHold, busy, done, error, bytesWritten, busOut};
  endfunction

  initial begin
    clearN = 1'b0; start = 1'b0; abort = 1'b0; rxData = 8'h00; rxValid = 1'b0;
    marModel = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outputs", allOutputs(), 32'd0);
    clearN = 1'b1;
    @(posedge clk); #1;

    // Abort beats start in IDLE.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checkOutput("start+abort stays idle", allOutputs(), 32'd0);

    // Nominal frame.
    frameData = '{8'h1E, 8'h2F, 8'hE0};
    runFrame(8'h03, 8'h2D, 1'b0);
    checkFrame("nominal", 1'b1, 3);

    // Bad checksum still writes every byte.
    runFrame(8'h03, 8'h2C, 1'b0);
    checkFrame("badsum", 1'b0, 3);

    // Zero and oversize length both mean a full 16-byte load.
    frameData.delete();
    for (int i = 1; i <= 16; i++) frameData.push_back(8'(i));
    runFrame(8'h00, 8'h88, 1'b0);
    checkFrame("len0", 1'b1, 16);
    runFrame(8'h25, 8'h88, 1'b0);
    checkFrame("len25", 1'b1, 16);

    // Stalled stream must give the same strobe sequence.
    frameData = '{8'h1E, 8'h2F, 8'hE0};
    runFrame(8'h03, 8'h2D, 1'b1);
    checkFrame("stall", 1'b1, 3);

    // Abort during the second SET_ADDR.
    clearLogs();
    pulseStart();
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h1E, 1'b0);
    applyStimulus(8'h2F, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    waitIdle();
    checkFrame("abort", 1'b0, 1);

    // Recovery after abort.
    runFrame(8'h03, 8'h2D, 1'b0);
    checkFrame("recover", 1'b1, 3);

    // Asynchronous reset in the middle of a WRITE cycle.
    clearLogs();
    pulseStart();
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h1E, 1'b0);
    @(posedge clk); #1;
    checkOutput("in WRITE before reset", {31'd0, ramWe}, 32'd1);
    clearN = 1'b0;
    #1;
    checkOutput("async reset outputs", allOutputs(), 32'd0);
    @(posedge clk); #1;
    clearN = 1'b1;
    @(negedge clk);
    checkOutput("idle after reset", allOutputs(), 32'd0);

    checkOutput("strobe/bus rules", violations, 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
